// File: rtl/serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : serial_loader
// Purpose  : Buffers parallel words in a small FIFO and streams each one
//            bit-serially (data, enable strobe, direction) into a downstream
//            shift register, back-to-back when words are queued.
// Revision : 1.0 - initial release
// ============================================================================
module serial_loader #(
  parameter int REG_LEN = 4,
  parameter int DEPTH   = 2,
  parameter int DIV     = 1
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic [REG_LEN-1:0] s_data,
  input  logic               s_msb_first,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               data_out,
  output logic               en_out,
  output logic               dir_out,
  output logic               word_done,
  output logic               busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BIT_W  = $clog2(REG_LEN);
  localparam int PACE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(REG_LEN - 1);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [REG_LEN:0]   fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [REG_LEN-1:0] shreg_q, shreg_d;
  logic               dir_q, dir_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [PACE_W-1:0]  pace_q, pace_d;

  logic               push;
  logic               pop;
  logic               tick;
  logic               last_bit;
  logic               fifo_empty;
  logic [REG_LEN:0]   head;

  assign fifo_empty = (count_q == '0);
  assign s_ready    = (count_q < CNT_FULL);
  assign push       = s_valid && s_ready;
  assign busy       = (state_q == ST_SHIFT);
  assign tick       = busy && (pace_q == PACE_LAST);
  assign last_bit   = tick && (bit_q == BIT_LAST);
  assign head       = fifo_q[rd_ptr_q];

  assign en_out    = tick;
  assign word_done = last_bit;
  assign dir_out   = dir_q;
  // The outgoing bit always sits at the end the shifter drains from.
  assign data_out  = busy && (dir_q ? shreg_q[REG_LEN-1] : shreg_q[0]);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    bit_d   = bit_q;
    pace_d  = pace_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          pace_d  = '0;
          bit_d   = bit_q + BIT_W'(1);
          shreg_d = dir_q ? {shreg_q[REG_LEN-2:0], 1'b0}
                          : {1'b0, shreg_q[REG_LEN-1:1]};
        end else begin
          pace_d = pace_q + PACE_W'(1);
        end
        // Reloading on the last strobe keeps a queued word gap-free.
        if (last_bit) begin
          bit_d = '0;
          if (fifo_empty) begin
            state_d = ST_IDLE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (pop) begin
      shreg_d = head[REG_LEN-1:0];
      dir_d   = head[REG_LEN];
      bit_d   = '0;
      pace_d  = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst && push) begin
      fifo_q[wr_ptr_q] <= {s_msb_first, s_data};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shreg_q  <= '0;
      dir_q    <= 1'b0;
      bit_q    <= '0;
      pace_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shreg_q  <= shreg_d;
      dir_q    <= dir_d;
      bit_q    <= bit_d;
      pace_q   <= pace_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_loader
// Purpose  : Randomized scoreboard bench for serial_loader (DIV=1) plus a
//            directed pacing run on a DIV=3 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_data_a, s_data_b;
  logic       s_msb_a, s_msb_b;
  logic       s_valid_a, s_valid_b;
  logic       s_ready_a, s_ready_b;
  logic       data_a, en_a, dir_a, done_a, busy_a;
  logic       data_b, en_b, dir_b, done_b, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit sb_en   = 1'b0;

  typedef struct {
    int         cyc;
    bit         b;
    bit         dir;
    bit         done;
    logic [3:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   pop_q[$];
  int   last_end = -100;
  logic [3:0] shadow_a = '0;
  int   a_strobes = 0;
  int   a_dones   = 0;

  serial_loader #(.REG_LEN(4), .DEPTH(2), .DIV(1)) u_dut (
    .clk_in(clk), .rst(rst), .s_data(s_data_a), .s_msb_first(s_msb_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .data_out(data_a),
    .en_out(en_a), .dir_out(dir_a), .word_done(done_a), .busy(busy_a)
  );

  serial_loader #(.REG_LEN(4), .DEPTH(2), .DIV(3)) u_dut_div3 (
    .clk_in(clk), .rst(rst), .s_data(s_data_b), .s_msb_first(s_msb_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .data_out(data_b),
    .en_out(en_b), .dir_out(dir_b), .word_done(done_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en_a) a_strobes <= a_strobes + 1;
    if (done_a) a_dones <= a_dones + 1;
  end

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Words held in the FIFO during cycle c: accepted before c, not yet popped before c.
  function automatic int exp_count(input int c);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] < c) n++;
    foreach (pop_q[i]) if (pop_q[i] < c) n--;
    return n;
  endfunction

  // A word starts two cycles after acceptance, or right after the previous word.
  task automatic model_accept(input logic [3:0] d, input logic m, input int t);
    int s;
    s = (t + 2 > last_end + 1) ? t + 2 : last_end + 1;
    acc_q.push_back(t);
    pop_q.push_back(s - 1);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.cyc  = s + i;
      e.b    = m ? d[3-i] : d[i];
      e.dir  = m;
      e.done = (i == 3);
      e.word = d;
      exp_q.push_back(e);
    end
    last_end = s + 3;
  endtask

  // Called at a negedge; returns one negedge after the word is presented, valid left high.
  task automatic push_word(input logic [3:0] d, input logic m);
    int guard = 0;
    while (!s_ready_a && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check(s_ready_a == 1'b1, "ready_timeout", s_ready_a, 1);
    if (s_ready_a) begin
      s_valid_a = 1'b1;
      s_data_a  = d;
      s_msb_a   = m;
      if (sb_en) model_accept(d, m, cyc);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check(exp_q.size() == 0, "drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sb_en && !rst) begin
      check(s_ready_a == (exp_count(cyc) < 2), "s_ready", s_ready_a, exp_count(cyc) < 2);
      if (en_a) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(cyc == e.cyc, "strobe_cycle", cyc, e.cyc);
          check(data_a == e.b, "data_out", data_a, e.b);
          check(dir_a == e.dir, "dir_out", dir_a, e.dir);
          check(done_a == e.done, "word_done", done_a, e.done);
          if (dir_a) shadow_a = {shadow_a[2:0], data_a};
          else       shadow_a = {data_a, shadow_a[3:1]};
          if (e.done) check(shadow_a == e.word, "downstream_word", shadow_a, e.word);
        end
      end else begin
        check(done_a == 1'b0, "done_without_strobe", done_a, 0);
        if (!busy_a) check(data_a == 1'b0, "idle_data_out", data_a, 0);
      end
    end
  end

  initial begin
    logic [3:0] b_word;
    logic [3:0] shadow_b;
    int         base_s, base_d;

    rst = 1'b1;
    s_valid_a = 1'b0; s_data_a = '0; s_msb_a = 1'b0;
    s_valid_b = 1'b0; s_data_b = '0; s_msb_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({data_a, en_a, dir_a, done_a, busy_a} == 5'b0, "reset_outputs_a",
          {data_a, en_a, dir_a, done_a, busy_a}, 0);
    check(s_ready_a == 1'b1, "reset_ready_a", s_ready_a, 1);
    check({data_b, en_b, dir_b, done_b, busy_b} == 5'b0, "reset_outputs_b",
          {data_b, en_b, dir_b, done_b, busy_b}, 0);
    check(s_ready_b == 1'b1, "reset_ready_b", s_ready_b, 1);
    rst = 1'b0;
    @(negedge clk);
    sb_en = 1'b1;

    push_word(4'b1011, 1'b1);
    s_valid_a = 1'b0;
    drain();
    push_word(4'b1011, 1'b0);
    s_valid_a = 1'b0;
    drain();

    push_word(4'h3, 1'b1);
    push_word(4'hC, 1'b0);
    push_word(4'h5, 1'b1);
    s_valid_a = 1'b0;
    drain();

    for (int i = 0; i < 120; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        s_valid_a = 1'b0;
        s_data_a  = 4'($urandom);
        repeat (gap) @(negedge clk);
      end
      push_word(4'($urandom), 1'($urandom));
    end
    s_valid_a = 1'b0;
    drain();

    // DIV=3 pacing: strobes every third cycle, busy for 12 cycles.
    b_word   = 4'b0110;
    shadow_b = '0;
    check(s_ready_b == 1'b1, "div3_ready", s_ready_b, 1);
    s_valid_b = 1'b1; s_data_b = b_word; s_msb_b = 1'b1;
    @(negedge clk);
    s_valid_b = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      bit eb, ee;
      eb = (k >= 2) && (k <= 13);
      ee = eb && ((k - 1) % 3 == 0);
      check(busy_b == eb, "div3_busy", busy_b, eb);
      check(en_b == ee, "div3_en", en_b, ee);
      check(done_b == (ee && k == 13), "div3_done", done_b, ee && k == 13);
      if (ee) begin
        check(data_b == b_word[3 - (k - 4) / 3], "div3_data", data_b, b_word[3 - (k - 4) / 3]);
        check(dir_b == 1'b1, "div3_dir", dir_b, 1);
        shadow_b = {shadow_b[2:0], data_b};
      end else if (!eb) begin
        check(data_b == 1'b0, "div3_idle_data", data_b, 0);
      end
      @(negedge clk);
    end
    check(shadow_b == b_word, "div3_downstream", shadow_b, b_word);

    // Reset mid-word with a second word queued.
    sb_en = 1'b0;
    push_word(4'hA, 1'b1);
    push_word(4'h6, 1'b0);
    s_valid_a = 1'b0;
    check(en_a == 1'b1, "pre_rst_strobe1", en_a, 1);
    @(negedge clk);
    check(en_a == 1'b1, "pre_rst_strobe2", en_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check(busy_a == 1'b0, "post_rst_busy", busy_a, 0);
    check(en_a == 1'b0, "post_rst_en", en_a, 0);
    check(s_ready_a == 1'b1, "post_rst_fifo_empty", s_ready_a, 1);
    check(done_a == 1'b0, "post_rst_done", done_a, 0);
    check(data_a == 1'b0, "post_rst_data", data_a, 0);
    base_s = a_strobes;
    base_d = a_dones;
    repeat (20) @(negedge clk);
    check(a_strobes == base_s, "post_rst_strobes", a_strobes - base_s, 0);
    check(a_dones == base_d, "post_rst_dones", a_dones - base_d, 0);
    check(busy_a == 1'b0, "post_rst_stays_idle", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
